// File: rtl/pipe_ctrl_unit.sv
// EX-stage control decode for the 3-stage MIPS core, with branch squash window,
// hi/lo scoreboard for the multi-cycle multiplier and a registered WB control stage.
module pipe_ctrl_unit #(
  parameter int unsigned MULT_LAT       = 4,
  parameter int unsigned BRANCH_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_EX,
  input  logic        instr_valid,
  input  logic        zero_EX,
  output logic [3:0]  alu_op,
  output logic [4:0]  shamt_EX,
  output logic        enhilo_EX,
  output logic [1:0]  regsel_EX,
  output logic        regwrite_EX,
  output logic        rdrt_EX,
  output logic        lui_EX,
  output logic [1:0]  alu_src_EX,
  output logic        gpio_out_EX,
  output logic        gpio_in_EX,
  output logic [1:0]  pc_src_EX,
  output logic        stall_FETCH,
  output logic        hilo_busy,
  output logic        illegal_EX,
  output logic        err_illegal,
  output logic        regwrite_WB,
  output logic [1:0]  regsel_WB,
  output logic        gpio_in_WB,
  output logic [4:0]  wdest_WB
);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_NOR   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  // mcnt holds the busy cycles left after issue, so hi/lo become readable MULT_LAT cycles after issue
  localparam logic [3:0] MULT_LOAD   = 4'(MULT_LAT - 1);
  localparam logic [1:0] SQUASH_LOAD = 2'(BRANCH_BUBBLES);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic [4:0] sh_s;
  logic [3:0] mcnt_r;
  logic [1:0] squash_cnt_r;

  logic [3:0] dec_alu_op_s;
  logic [4:0] dec_shamt_s;
  logic       dec_enhilo_s;
  logic [1:0] dec_regsel_s;
  logic       dec_regwrite_s;
  logic       dec_rdrt_s;
  logic       dec_lui_s;
  logic [1:0] dec_alu_src_s;
  logic       dec_gpio_out_s;
  logic       dec_gpio_in_s;
  logic       dec_beq_s;
  logic       dec_bne_s;
  logic       dec_j_s;
  logic       dec_hilo_use_s;
  logic       dec_illegal_s;

  logic       busy_s;
  logic       squashing_s;
  logic       stall_s;
  logic       active_s;
  logic       taken_s;
  logic       mult_issue_s;
  logic [4:0] wdest_s;

  assign opcode_s = instruction_EX[31:26];
  assign funct_s  = instruction_EX[5:0];
  assign sh_s     = instruction_EX[10:6];

  // Ungated decode of the EX instruction word
  always_comb begin
    dec_alu_op_s   = ALU_AND;
    dec_shamt_s    = 5'd0;
    dec_enhilo_s   = 1'b0;
    dec_regsel_s   = 2'd0;
    dec_regwrite_s = 1'b0;
    dec_rdrt_s     = 1'b0;
    dec_lui_s      = 1'b0;
    dec_alu_src_s  = 2'd0;
    dec_gpio_out_s = 1'b0;
    dec_gpio_in_s  = 1'b0;
    dec_beq_s      = 1'b0;
    dec_bne_s      = 1'b0;
    dec_j_s        = 1'b0;
    dec_hilo_use_s = 1'b0;
    dec_illegal_s  = 1'b0;
    if (instruction_EX == 32'd0) begin
      dec_illegal_s = 1'b0;
    end else begin
      case (opcode_s)
        6'b000000: begin
          case (funct_s)
            6'b000000: begin
              dec_alu_op_s   = ALU_SLL;
              dec_shamt_s    = sh_s;
              dec_regwrite_s = 1'b1;
            end
            6'b000010: begin
              if (sh_s == 5'd0) begin
                dec_gpio_out_s = 1'b1;
              end else begin
                dec_alu_op_s   = ALU_SRL;
                dec_shamt_s    = sh_s;
                dec_regwrite_s = 1'b1;
              end
            end
            6'b000011: begin
              if (sh_s == 5'd0) begin
                dec_gpio_in_s  = 1'b1;
                dec_regwrite_s = 1'b1;
              end else begin
                dec_alu_op_s   = ALU_SRA;
                dec_shamt_s    = sh_s;
                dec_regwrite_s = 1'b1;
              end
            end
            6'b010000: begin
              dec_regsel_s   = 2'd1;
              dec_regwrite_s = 1'b1;
              dec_hilo_use_s = 1'b1;
            end
            6'b010010: begin
              dec_regsel_s   = 2'd2;
              dec_regwrite_s = 1'b1;
              dec_hilo_use_s = 1'b1;
            end
            6'b011000: begin
              dec_alu_op_s   = ALU_MULT;
              dec_enhilo_s   = 1'b1;
              dec_hilo_use_s = 1'b1;
            end
            6'b011001: begin
              dec_alu_op_s   = ALU_MULTU;
              dec_enhilo_s   = 1'b1;
              dec_hilo_use_s = 1'b1;
            end
            6'b100000, 6'b100001: begin dec_alu_op_s = ALU_ADD;  dec_regwrite_s = 1'b1; end
            6'b100010, 6'b100011: begin dec_alu_op_s = ALU_SUB;  dec_regwrite_s = 1'b1; end
            6'b100100:            begin dec_alu_op_s = ALU_AND;  dec_regwrite_s = 1'b1; end
            6'b100101:            begin dec_alu_op_s = ALU_OR;   dec_regwrite_s = 1'b1; end
            6'b100110:            begin dec_alu_op_s = ALU_XOR;  dec_regwrite_s = 1'b1; end
            6'b100111:            begin dec_alu_op_s = ALU_NOR;  dec_regwrite_s = 1'b1; end
            6'b101010:            begin dec_alu_op_s = ALU_SLT;  dec_regwrite_s = 1'b1; end
            6'b101011:            begin dec_alu_op_s = ALU_SLTU; dec_regwrite_s = 1'b1; end
            default:              dec_illegal_s = 1'b1;
          endcase
        end
        6'b001000, 6'b001001: begin
          dec_alu_op_s = ALU_ADD; dec_alu_src_s = 2'd1; dec_rdrt_s = 1'b1; dec_regwrite_s = 1'b1;
        end
        6'b001100: begin dec_alu_op_s = ALU_AND; dec_alu_src_s = 2'd2; dec_rdrt_s = 1'b1; dec_regwrite_s = 1'b1; end
        6'b001101: begin dec_alu_op_s = ALU_OR;  dec_alu_src_s = 2'd2; dec_rdrt_s = 1'b1; dec_regwrite_s = 1'b1; end
        6'b001110: begin dec_alu_op_s = ALU_XOR; dec_alu_src_s = 2'd2; dec_rdrt_s = 1'b1; dec_regwrite_s = 1'b1; end
        6'b001010: begin dec_alu_op_s = ALU_SLT; dec_alu_src_s = 2'd1; dec_rdrt_s = 1'b1; dec_regwrite_s = 1'b1; end
        6'b001111: begin
          // lui is the zero-extended immediate shifted left by 16
          dec_alu_op_s   = ALU_SLL;
          dec_shamt_s    = 5'd16;
          dec_alu_src_s  = 2'd2;
          dec_lui_s      = 1'b1;
          dec_rdrt_s     = 1'b1;
          dec_regwrite_s = 1'b1;
        end
        6'b000100: begin dec_alu_op_s = ALU_SUB; dec_beq_s = 1'b1; end
        6'b000101: begin dec_alu_op_s = ALU_SUB; dec_bne_s = 1'b1; end
        6'b000010: dec_j_s = 1'b1;
        default:   dec_illegal_s = 1'b1;
      endcase
    end
  end

  assign busy_s       = (mcnt_r != 4'd0) && !rst;
  assign squashing_s  = (squash_cnt_r != 2'd0);
  assign stall_s      = !rst && instr_valid && !squashing_s && busy_s && dec_hilo_use_s;
  assign active_s     = !rst && instr_valid && !squashing_s && !stall_s;
  assign taken_s      = active_s && ((dec_beq_s && zero_EX) || (dec_bne_s && !zero_EX) || dec_j_s);
  assign mult_issue_s = active_s && dec_enhilo_s;
  assign stall_FETCH  = stall_s;
  assign hilo_busy    = busy_s;

  // Slot gating: only an active, legal slot drives EX controls
  always_comb begin
    alu_op      = 4'b0000;
    shamt_EX    = 5'd0;
    enhilo_EX   = 1'b0;
    regsel_EX   = 2'd0;
    regwrite_EX = 1'b0;
    rdrt_EX     = 1'b0;
    lui_EX      = 1'b0;
    alu_src_EX  = 2'd0;
    gpio_out_EX = 1'b0;
    gpio_in_EX  = 1'b0;
    pc_src_EX   = 2'd0;
    illegal_EX  = 1'b0;
    wdest_s     = 5'd0;
    if (active_s) begin
      if (dec_illegal_s) begin
        illegal_EX = 1'b1;
      end else begin
        alu_op      = dec_alu_op_s;
        shamt_EX    = dec_shamt_s;
        enhilo_EX   = dec_enhilo_s;
        regsel_EX   = dec_regsel_s;
        regwrite_EX = dec_regwrite_s;
        rdrt_EX     = dec_rdrt_s;
        lui_EX      = dec_lui_s;
        alu_src_EX  = dec_alu_src_s;
        gpio_out_EX = dec_gpio_out_s;
        gpio_in_EX  = dec_gpio_in_s;
        wdest_s     = dec_rdrt_s ? instruction_EX[20:16] : instruction_EX[15:11];
        if (dec_j_s) begin
          pc_src_EX = 2'd2;
        end else if (taken_s) begin
          pc_src_EX = 2'd1;
        end else begin
          pc_src_EX = 2'd0;
        end
      end
    end else begin
      illegal_EX = 1'b0;
    end
  end

  // Squash/multiply counters, sticky illegal flag and WB control stage
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_cnt_r <= 2'd0;
      mcnt_r       <= 4'd0;
      err_illegal  <= 1'b0;
      regwrite_WB  <= 1'b0;
      regsel_WB    <= 2'd0;
      gpio_in_WB   <= 1'b0;
      wdest_WB     <= 5'd0;
    end else begin
      if (taken_s) begin
        squash_cnt_r <= SQUASH_LOAD;
      end else if (squashing_s) begin
        squash_cnt_r <= squash_cnt_r - 2'd1;
      end else begin
        squash_cnt_r <= squash_cnt_r;
      end
      if (mult_issue_s) begin
        mcnt_r <= MULT_LOAD;
      end else if (mcnt_r != 4'd0) begin
        mcnt_r <= mcnt_r - 4'd1;
      end else begin
        mcnt_r <= mcnt_r;
      end
      err_illegal <= err_illegal | illegal_EX;
      regwrite_WB <= regwrite_EX && (wdest_s != 5'd0);
      regsel_WB   <= regsel_EX;
      gpio_in_WB  <= gpio_in_EX;
      wdest_WB    <= wdest_s;
    end
  end

endmodule
